// File: rtl/fiapp_pkg.sv
// Shared types and constants for the fault-injection checker slice.
package fiapp_pkg;

  localparam int FIAPP_CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_HALT   = 2'd3
  } fiapp_state_e;

endpackage

// File: rtl/fiapp_shadow.sv
// Fault-free reference of the injection stage: load flop plus two followers.
module fiapp_shadow (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic enable,
  output logic m1,
  output logic m2,
  output logic m3
);

  logic r_m1, r_m2, r_m3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m1 <= 1'b0;
      r_m2 <= 1'b0;
      r_m3 <= 1'b0;
    end else begin
      if (enable) r_m1 <= a;
      r_m2 <= r_m1;
      r_m3 <= ~r_m1;
    end
  end

  assign m1 = r_m1;
  assign m2 = r_m2;
  assign m3 = r_m3;

endmodule

// File: rtl/fiapp_checker.sv
// Compares the injection stage against a shadow model and logs mismatches.
// Define FIAPP_CHECKER_HALT_ON_FAULT_EN to stop checking at the first mismatch.
module fiapp_checker
  import fiapp_pkg::*;
#(
  parameter int CNT_W      = FIAPP_CNT_W_DEF,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             enable,
  input  logic             o1,
  input  logic             o2,
  input  logic             o3,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             fault_det,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] first_err_cyc,
  output logic [2:0]       first_err_vec
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic         w_m1, w_m2, w_m3;
  logic [2:0]   w_mis;
  logic         w_mis_any;
  fiapp_state_e r_state, w_nxt_state;
  logic [SET_W-1:0] r_settle;
  logic             r_busy, r_fdet;
  logic [CNT_W-1:0] r_err, r_cyc, r_ferr_cyc;
  logic [2:0]       r_fvec;

  fiapp_shadow u_shadow (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .enable (enable),
    .m1     (w_m1),
    .m2     (w_m2),
    .m3     (w_m3)
  );

  assign w_mis     = {o3 ^ w_m3, o2 ^ w_m2, o1 ^ w_m1};
  assign w_mis_any = |w_mis;

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE, ST_HALT:
        if (start) w_nxt_state = (SETTLE_CYC == 0) ? ST_CHECK : ST_SETTLE;
      ST_SETTLE:
        if (r_settle == SET_W'(SETTLE_CYC - 1)) w_nxt_state = ST_CHECK;
      ST_CHECK: begin
        if (stop) w_nxt_state = ST_HALT;
`ifdef FIAPP_CHECKER_HALT_ON_FAULT_EN
        if (w_mis_any) w_nxt_state = ST_HALT;
`endif
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_settle   <= '0;
      r_busy     <= 1'b0;
      r_fdet     <= 1'b0;
      r_err      <= '0;
      r_cyc      <= '0;
      r_ferr_cyc <= '0;
      r_fvec     <= '0;
    end else begin
      r_state <= w_nxt_state;
      // busy is registered from the next state so it lines up with the state it describes
      r_busy  <= (w_nxt_state == ST_SETTLE) || (w_nxt_state == ST_CHECK);
      case (r_state)
        ST_IDLE, ST_HALT:
          if (start) begin
            r_settle   <= '0;
            r_fdet     <= 1'b0;
            r_err      <= '0;
            r_cyc      <= '0;
            r_ferr_cyc <= '0;
            r_fvec     <= '0;
          end
        ST_SETTLE:
          r_settle <= r_settle + {{(SET_W-1){1'b0}}, 1'b1};
        ST_CHECK: begin
          r_cyc <= sat_inc(r_cyc);
          if (w_mis_any) begin
            r_err  <= sat_inc(r_err);
            r_fdet <= 1'b1;
            if (!r_fdet) begin
              r_ferr_cyc <= r_cyc;
              r_fvec     <= w_mis;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = r_busy;
  assign fault_det     = r_fdet;
  assign err_cnt       = r_err;
  assign cyc_cnt       = r_cyc;
  assign first_err_cyc = r_ferr_cyc;
  assign first_err_vec = r_fvec;

endmodule

// File: tb/tb_fiapp_checker.sv
// Directed bench: a fault-free injection stage with XOR fault overlay feeds two checkers.
module tb_fiapp_checker;

  logic clk = 1'b0;
  logic reset, a, enable, start, stop;
  logic [2:0] inj;
  logic g1, g2, g3;
  logic o1, o2, o3;

  logic        busy, fdet;
  logic [15:0] err, cyc, fcyc;
  logic [2:0]  fvec;
  logic        busy4, fdet4;
  logic [3:0]  err4, cyc4, fcyc4;
  logic [2:0]  fvec4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] err, cyc, fcyc;
    logic        fdet;
    logic [2:0]  fvec;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Reference injection stage; faults are XORed on top of its outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g1 <= 1'b0; g2 <= 1'b0; g3 <= 1'b0;
    end else begin
      if (enable) g1 <= a;
      g2 <= g1;
      g3 <= ~g1;
    end
  end
  assign o1 = g1 ^ inj[0];
  assign o2 = g2 ^ inj[1];
  assign o3 = g3 ^ inj[2];

  fiapp_checker u_dut (
    .clk(clk), .reset(reset), .a(a), .enable(enable),
    .o1(o1), .o2(o2), .o3(o3), .start(start), .stop(stop),
    .busy(busy), .fault_det(fdet), .err_cnt(err), .cyc_cnt(cyc),
    .first_err_cyc(fcyc), .first_err_vec(fvec)
  );

  fiapp_checker #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .a(a), .enable(enable),
    .o1(o1), .o2(o2), .o3(o3), .start(start), .stop(stop),
    .busy(busy4), .fault_det(fdet4), .err_cnt(err4), .cyc_cnt(cyc4),
    .first_err_cyc(fcyc4), .first_err_vec(fvec4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input string tag, input int e, input int c, input bit fd,
                      input int fc, input logic [2:0] fv);
    exp_t x;
    x.tag = tag; x.err = 16'(e); x.cyc = 16'(c); x.fdet = fd; x.fcyc = 16'(fc); x.fvec = fv;
    sb.push_back(x);
  endtask

  task automatic check_res();
    exp_t x;
    x = sb.pop_front();
    chk({x.tag, ".err"},  32'(err),  32'(x.err));
    chk({x.tag, ".cyc"},  32'(cyc),  32'(x.cyc));
    chk({x.tag, ".fdet"}, 32'(fdet), 32'(x.fdet));
    chk({x.tag, ".fcyc"}, 32'(fcyc), 32'(x.fcyc));
    chk({x.tag, ".fvec"}, 32'(fvec), 32'(x.fvec));
    chk({x.tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  // Start pulse plus the two SETTLE cycles; returns with the DUT in CHECK, cyc_cnt=0.
  task automatic arm();
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
  endtask

  // n CHECK cycles; injections at cycles k0/k1, vall on every cycle, stop on the last.
  task automatic run(input int n, input int k0, input logic [2:0] v0, input int k1,
                     input logic [2:0] v1, input logic [2:0] vall, input bit do_stop);
    for (int k = 0; k < n; k++) begin
      a      = 1'($urandom_range(1, 0));
      enable = 1'($urandom_range(1, 0));
      inj    = vall | ((k == k0) ? v0 : 3'b000) | ((k == k1) ? v1 : 3'b000);
      stop   = do_stop && (k == n - 1);
      tick();
    end
    inj = 3'b000; stop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; a = 1'b0; enable = 1'b0; start = 1'b0; stop = 1'b0; inj = 3'b000;
    repeat (2) tick();
    push("rst", 0, 0, 1'b0, 0, 3'b000);
    check_res();
    reset = 1'b0;
    tick();

    arm(); run(20, -1, 3'b000, -1, 3'b000, 3'b000, 1'b1);
    push("clean", 0, 20, 1'b0, 0, 3'b000);
    check_res();

    arm(); run(20, 5, 3'b001, -1, 3'b000, 3'b000, 1'b1);
`ifdef FIAPP_CHECKER_HALT_ON_FAULT_EN
    push("single", 1, 6, 1'b1, 5, 3'b001);
`else
    push("single", 1, 20, 1'b1, 5, 3'b001);
`endif
    check_res();

`ifdef FIAPP_CHECKER_HALT_ON_FAULT_EN
    arm(); run(10, 4, 3'b001, 7, 3'b100, 3'b000, 1'b1);
    push("haltf", 1, 5, 1'b1, 4, 3'b001);
    check_res();
`else
    arm(); run(20, 3, 3'b110, 7, 3'b001, 3'b000, 1'b1);
    push("multi", 2, 20, 1'b1, 3, 3'b110);
    check_res();

    arm(); run(20, -1, 3'b000, -1, 3'b000, 3'b001, 1'b1);
    push("sat16", 20, 20, 1'b1, 0, 3'b001);
    check_res();
    chk("sat4.err", 32'(err4), 32'hF);
    chk("sat4.cyc", 32'(cyc4), 32'hF);

    arm(); run(6, 5, 3'b010, -1, 3'b000, 3'b000, 1'b1);
    push("stopmis", 1, 6, 1'b1, 5, 3'b010);
    push("hold", 1, 6, 1'b1, 5, 3'b010);
    check_res();
    run(4, -1, 3'b000, -1, 3'b000, 3'b111, 1'b1);
    check_res();
`endif

    // start and stop together from IDLE must arm, not halt
    reset = 1'b1; tick(); reset = 1'b0; tick();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("ss.busy", 32'(busy), 32'd1);
    repeat (2) tick();
    run(3, -1, 3'b000, -1, 3'b000, 3'b000, 1'b0);
    chk("ss.cyc", 32'(cyc), 32'd3);
    chk("ss.busy2", 32'(busy), 32'd1);

    // async reset in the middle of CHECK cycle 10
    reset = 1'b1; tick(); reset = 1'b0; tick();
    arm(); run(10, 2, 3'b011, -1, 3'b000, 3'b000, 1'b0);
    chk("pre.cyc", 32'(cyc), 32'd10);
    #2 reset = 1'b1;
    #1;
    push("midrst", 0, 0, 1'b0, 0, 3'b000);
    check_res();
    chk("midrst.err4", 32'(err4), 32'd0);
    chk("midrst.busy4", 32'(busy4), 32'd0);
    #1 reset = 1'b0;
    run(5, 1, 3'b001, -1, 3'b000, 3'b000, 1'b0);
    push("idle", 0, 0, 1'b0, 0, 3'b000);
    check_res();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
